// File: rtl/bus_arb_pkg.sv
// Shared definitions for the two-master bus arbiter.
//   - State encodings for the arbiter FSM (IDLE / ACCESS / DONE)
//   - Master index constants
//   - Width of the wait-state counter
//   - Helper that turns a master index into a one-hot grant vector
package bus_arb_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = S_IDLE,
        ST_ACCESS = S_ACCESS,
        ST_DONE   = S_DONE
    } arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int WAIT_CW = 4;

    function automatic logic [1:0] idx_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/bus_arb_rr.sv
// Combinational two-way round-robin picker.
//   req_i[1:0]  pending requests, bit0 = master 0, bit1 = master 1
//   last_i      index of the master served most recently
//   win_idx_o   index of the master to serve next (only meaningful when any_req_o)
//   any_req_o   at least one request is pending
module bus_arb_rr
    import bus_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       win_idx_o,
    output logic       any_req_o
);

    always_comb begin
        any_req_o = |req_i;
        win_idx_o = M0;
        if (req_i == 2'b11) begin
            // Tie: whoever was not served last goes first.
            win_idx_o = ~last_i;
        end else if (req_i[1]) begin
            win_idx_o = M1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter in front of the single Bridge data bus.
//   cpu_clk / cpu_rst        clock, asynchronous active-low reset
//   m0_* (CPU), m1_* (DMA)   req/addr/we/wdata in, ack/rdata out per master
//   Bus_addr/Bus_we/Bus_wdata  drive the Bridge; Bus_rdata is its combinational read data
//   gnt                      one-hot owner during ACCESS, 00 otherwise
//
// Handshake: a master raises req with stable addr/we/wdata and keeps them until
// it sees its one-cycle ack. rdata is valid in the ack cycle and holds until that
// master's next completion. A req still high in the IDLE cycle after ack is a new
// transaction, so the master must drop req (or present its next request) by the
// edge that ends the ack cycle. Fields are only sampled in IDLE.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int BUS_WAIT = 0,
    parameter int ADDR_W   = 32
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_we,
    input  logic [31:0]       m0_wdata,
    output logic              m0_ack,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_we,
    input  logic [31:0]       m1_wdata,
    output logic              m1_ack,
    output logic [31:0]       m1_rdata,
    output logic [ADDR_W-1:0] Bus_addr,
    output logic              Bus_we,
    output logic [31:0]       Bus_wdata,
    input  logic [31:0]       Bus_rdata,
    output logic [1:0]        gnt
);

    localparam logic [WAIT_CW-1:0] WAIT_INIT = WAIT_CW'(BUS_WAIT);
    localparam logic [WAIT_CW-1:0] CNT_ONE   = WAIT_CW'(1);

    arb_state_e          state_q,  state_d;
    logic [WAIT_CW-1:0]  cnt_q,    cnt_d;
    logic                idx_q,    idx_d;
    logic                last_q,   last_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic                we_q,     we_d;
    logic [31:0]         wdata_q,  wdata_d;
    logic [31:0]         rdata0_q, rdata0_d;
    logic [31:0]         rdata1_q, rdata1_d;

    logic win_idx;
    logic any_req;

    bus_arb_rr u_rr (
        .req_i     ({m1_req, m0_req}),
        .last_i    (last_q),
        .win_idx_o (win_idx),
        .any_req_o (any_req)
    );

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= M0;
            last_q   <= M1;   // so master 0 wins the first tie
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        last_d   = last_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_ACCESS;
                    cnt_d   = WAIT_INIT;
                    idx_d   = win_idx;
                    addr_d  = (win_idx == M1) ? m1_addr  : m0_addr;
                    we_d    = (win_idx == M1) ? m1_we    : m0_we;
                    wdata_d = (win_idx == M1) ? m1_wdata : m0_wdata;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    // Final ACCESS cycle: read data is captured even for writes
                    // (read-before-write value for the CPU's store merge).
                    state_d = ST_DONE;
                    last_d  = idx_q;
                    if (idx_q == M1) begin
                        rdata1_d = Bus_rdata;
                    end else begin
                        rdata0_d = Bus_rdata;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode from registered state only, so an asynchronous reset
    // drops gnt and Bus_we in the same cycle.
    assign Bus_addr  = addr_q;
    assign Bus_wdata = wdata_q;
    assign Bus_we    = (state_q == ST_ACCESS) && (cnt_q == '0) && we_q;
    assign gnt       = (state_q == ST_ACCESS) ? idx_onehot(idx_q) : 2'b00;
    assign m0_ack    = (state_q == ST_DONE) && (idx_q == M0);
    assign m1_ack    = (state_q == ST_DONE) && (idx_q == M1);
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: three instances (BUS_WAIT = 0, 3, 5) share one clock.
// Each has its own masters and a combinational Bridge model. A transaction-level
// reference model predicts every cycle from the acceptance cycle t:
// ACCESS in t+1..t+1+W, ack in t+2+W, next arbitration from t+3+W.
module tb_bus_arbiter;

  localparam int N = 3;

  logic cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  logic        rst_s  [N];
  logic        req_s  [N][2];
  logic [31:0] addr_s [N][2];
  logic        we_s   [N][2];
  logic [31:0] wd_s   [N][2];

  wire        ack_w   [N][2];
  wire [31:0] rd_w    [N][2];
  wire [31:0] baddr_w [N];
  wire        bwe_w   [N];
  wire [31:0] bwd_w   [N];
  wire [31:0] brd_w   [N];
  wire [1:0]  gnt_w   [N];

  function automatic logic [31:0] bridge(input logic [31:0] a);
    if (a == 32'h0000_1004) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int WV = (g == 0) ? 0 : (g == 1) ? 3 : 5;
    bus_arbiter #(.BUS_WAIT(WV), .ADDR_W(32)) u_dut (
      .cpu_clk   (cpu_clk),
      .cpu_rst   (rst_s[g]),
      .m0_req    (req_s[g][0]),
      .m0_addr   (addr_s[g][0]),
      .m0_we     (we_s[g][0]),
      .m0_wdata  (wd_s[g][0]),
      .m0_ack    (ack_w[g][0]),
      .m0_rdata  (rd_w[g][0]),
      .m1_req    (req_s[g][1]),
      .m1_addr   (addr_s[g][1]),
      .m1_we     (we_s[g][1]),
      .m1_wdata  (wd_s[g][1]),
      .m1_ack    (ack_w[g][1]),
      .m1_rdata  (rd_w[g][1]),
      .Bus_addr  (baddr_w[g]),
      .Bus_we    (bwe_w[g]),
      .Bus_wdata (bwd_w[g]),
      .Bus_rdata (brd_w[g]),
      .gnt       (gnt_w[g])
    );
    assign brd_w[g] = bridge(baddr_w[g]);
  end

  // ---------------- reference model state ----------------
  int          waits [N] = '{0, 3, 5};
  bit          cur_v    [N];
  bit          cur_who  [N];
  logic [31:0] cur_addr [N];
  logic [31:0] cur_wd   [N];
  bit          cur_we   [N];
  int          t_start  [N];
  bit          last_srv [N];
  logic [31:0] rd_exp   [N][2];
  bit          in_rst   [N];
  int          wr_txn   [N];
  int          we_cyc   [N];
  bit          rnd      [N];
  bit          renew    [N][2];
  bit          log_en;
  int          order_q[$];
  int          cyc;
  int          tests;
  int          failed;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    cur_v[k]     = 1'b0;
    last_srv[k]  = 1'b1;
    rd_exp[k][0] = '0;
    rd_exp[k][1] = '0;
    in_rst[k]    = 1'b1;
  endtask

  function automatic bit idle_at(input int k, input int c);
    return !cur_v[k] || (c >= t_start[k] + 3 + waits[k]);
  endfunction

  task automatic new_req(input int k, input int m);
    req_s[k][m] = 1'b1;
    we_s[k][m]  = 1'($urandom_range(0, 1));
    addr_s[k][m] = ($urandom_range(0, 3) == 0) ? 32'h0000_1004 : $urandom;
    wd_s[k][m]  = $urandom;
  endtask

  // Check all instances for the current cycle, then let the masters react.
  task automatic tick_check();
    @(negedge cpu_clk);
    for (int k = 0; k < N; k++) begin
      logic [1:0] e_gnt;
      logic       e_we;
      logic [1:0] e_ack;
      bit         acc;
      int         fin;
      fin   = t_start[k] + 1 + waits[k];
      acc   = cur_v[k] && (cyc > t_start[k]) && (cyc <= fin);
      e_gnt = 2'b00;
      e_we  = 1'b0;
      e_ack = 2'b00;
      if (acc) begin
        e_gnt = cur_who[k] ? 2'b10 : 2'b01;
        e_we  = cur_we[k] && (cyc == fin);
        chk("bus_addr", k, baddr_w[k], cur_addr[k]);
        chk("bus_wdata", k, bwd_w[k], cur_wd[k]);
      end
      if (cur_v[k] && (cyc == fin + 1)) begin
        e_ack[cur_who[k]] = 1'b1;
        rd_exp[k][cur_who[k]] = bridge(cur_addr[k]);
        if (cur_we[k]) wr_txn[k]++;
      end
      chk("gnt", k, 32'(gnt_w[k]), 32'(e_gnt));
      chk("bus_we", k, 32'(bwe_w[k]), 32'(e_we));
      chk("m0_ack", k, 32'(ack_w[k][0]), 32'(e_ack[0]));
      chk("m1_ack", k, 32'(ack_w[k][1]), 32'(e_ack[1]));
      chk("m0_rdata", k, rd_w[k][0], rd_exp[k][0]);
      chk("m1_rdata", k, rd_w[k][1], rd_exp[k][1]);
      if (bwe_w[k] === 1'b1) we_cyc[k]++;
      if (log_en && k == 1) begin
        if (ack_w[1][0] === 1'b1) order_q.push_back(0);
        if (ack_w[1][1] === 1'b1) order_q.push_back(1);
      end
      for (int m = 0; m < 2; m++) begin
        if (e_ack[m]) begin
          if (rnd[k]) begin
            if ($urandom_range(0, 1) == 1) new_req(k, m);
            else req_s[k][m] = 1'b0;
          end else if (!renew[k][m]) begin
            req_s[k][m] = 1'b0;
          end
        end else if (rnd[k]) begin
          if (!req_s[k][m]) begin
            if ($urandom_range(0, 3) == 0) new_req(k, m);
            else addr_s[k][m] = $urandom;
          end else if (acc && (int'(cur_who[k]) == m)) begin
            // Owner scribbles over its fields mid-ACCESS; must be ignored.
            addr_s[k][m] = $urandom;
            wd_s[k][m]   = $urandom;
            we_s[k][m]   = 1'($urandom_range(0, 1));
          end
        end
      end
    end
  endtask

  // Arbitration decision for the current cycle, from the inputs now applied.
  task automatic tick_model();
    for (int k = 0; k < N; k++) begin
      if (!in_rst[k] && idle_at(k, cyc) && (req_s[k][0] || req_s[k][1])) begin
        bit w;
        w = (req_s[k][0] && req_s[k][1]) ? !last_srv[k] : req_s[k][1];
        cur_v[k]    = 1'b1;
        cur_who[k]  = w;
        cur_addr[k] = addr_s[k][w];
        cur_we[k]   = we_s[k][w];
        cur_wd[k]   = wd_s[k][w];
        t_start[k]  = cyc;
        last_srv[k] = w;
      end
    end
    cyc++;
  endtask

  task automatic step();
    tick_check();
    tick_model();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    cyc    = 0;
    log_en = 1'b0;
    for (int k = 0; k < N; k++) begin
      rst_s[k]  = 1'b1;
      model_reset(k);
      rnd[k]    = 1'b0;
      wr_txn[k] = 0;
      we_cyc[k] = 0;
      for (int m = 0; m < 2; m++) begin
        req_s[k][m]  = 1'b0;
        addr_s[k][m] = '0;
        we_s[k][m]   = 1'b0;
        wd_s[k][m]   = '0;
        renew[k][m]  = 1'b0;
      end
    end

    // Reset: all outputs zero. Instance 1 has both masters requesting already.
    #1;
    for (int k = 0; k < N; k++) rst_s[k] = 1'b0;
    req_s[1][0] = 1'b1; addr_s[1][0] = 32'h0000_3000; we_s[1][0] = 1'b0;
    req_s[1][1] = 1'b1; addr_s[1][1] = 32'h0000_2000; we_s[1][1] = 1'b1; wd_s[1][1] = 32'h55;
    renew[1][0] = 1'b1;
    renew[1][1] = 1'b1;
    log_en = 1'b1;
    #1;
    for (int k = 0; k < N; k++) begin
      chk("rst_gnt", k, 32'(gnt_w[k]), 32'h0);
      chk("rst_we", k, 32'(bwe_w[k]), 32'h0);
      chk("rst_ack0", k, 32'(ack_w[k][0]), 32'h0);
      chk("rst_ack1", k, 32'(ack_w[k][1]), 32'h0);
      chk("rst_rd0", k, rd_w[k][0], 32'h0);
      chk("rst_rd1", k, rd_w[k][1], 32'h0);
      chk("rst_addr", k, baddr_w[k], 32'h0);
      chk("rst_wdata", k, bwd_w[k], 32'h0);
    end
    tick_check();
    tick_model();
    tick_check();
    for (int k = 0; k < N; k++) begin
      rst_s[k]  = 1'b1;
      in_rst[k] = 1'b0;
    end
    tick_model();

    // Tie from reset on instance 1; instances 0 and 2 stay idle meanwhile.
    begin
      int guard;
      guard = 0;
      while (order_q.size() < 4 && guard < 80) begin
        step();
        guard++;
      end
      chk("tie_timeout", 1, 32'(order_q.size() >= 4), 32'h1);
    end
    renew[1][0] = 1'b0;
    renew[1][1] = 1'b0;
    log_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int o;
      o = (i < order_q.size()) ? order_q[i] : -1;
      chk("tie_order", i, 32'(o), 32'(i % 2));
    end
    run(20);

    // Single read on instance 0 (W=0), single write on instance 1 (W=3).
    tick_check();
    req_s[0][0] = 1'b1; addr_s[0][0] = 32'h0000_1004; we_s[0][0] = 1'b0;
    req_s[1][1] = 1'b1; addr_s[1][1] = 32'h0000_4000; we_s[1][1] = 1'b1; wd_s[1][1] = 32'hA5A5_0001;
    tick_model();
    step();
    tick_check();
    chk("single_ack", 0, 32'(ack_w[0][0]), 32'h1);
    chk("single_rdata", 0, rd_w[0][0], 32'hDEAD_BEEF);
    tick_model();
    run(8);

    // Field change during ACCESS on instance 2 must be ignored.
    tick_check();
    req_s[2][0] = 1'b1; addr_s[2][0] = 32'h0000_0010; we_s[2][0] = 1'b0;
    tick_model();
    tick_check();
    addr_s[2][0] = 32'h0000_0020;
    tick_model();
    run(10);
    chk("chg_rdata", 2, rd_w[2][0], bridge(32'h0000_0010));

    // Reset in the 2nd ACCESS cycle of instance 2, then reissue.
    tick_check();
    req_s[2][1] = 1'b1; addr_s[2][1] = 32'h0000_5000; we_s[2][1] = 1'b1; wd_s[2][1] = 32'h77;
    tick_model();
    step();
    tick_check();
    rst_s[2] = 1'b0;
    model_reset(2);
    req_s[2][1] = 1'b0;
    #1;
    chk("midrst_gnt", 2, 32'(gnt_w[2]), 32'h0);
    chk("midrst_we", 2, 32'(bwe_w[2]), 32'h0);
    chk("midrst_ack0", 2, 32'(ack_w[2][0]), 32'h0);
    chk("midrst_ack1", 2, 32'(ack_w[2][1]), 32'h0);
    tick_model();
    run(3);
    tick_check();
    rst_s[2]  = 1'b1;
    in_rst[2] = 1'b0;
    req_s[2][1] = 1'b1;
    tick_model();
    run(10);
    chk("reissue_rdata", 2, rd_w[2][1], bridge(32'h0000_5000));

    // Randomized traffic on all instances, then drain.
    for (int k = 0; k < N; k++) rnd[k] = 1'b1;
    run(900);
    for (int k = 0; k < N; k++) rnd[k] = 1'b0;
    run(40);

    for (int k = 0; k < N; k++) begin
      chk("write_edges", k, 32'(we_cyc[k]), 32'(wr_txn[k]));
      chk("end_gnt", k, 32'(gnt_w[k]), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
